// File: rtl/mure_uop_buffer.sv
// Retire-port classification and uop buffering ahead of the trace encoder.
// Each retired lane is tagged with an itype, packed into an entry and stored in
// a circular buffer; entries leave one per cycle over a valid/ready port.
// A group that does not fit is dropped whole and recorded in a sticky flag.
module mure_uop_buffer #(
  parameter int NRET      = 2,
  parameter int DEPTH     = 16,
  parameter int ITYPE_LEN = 3,
`ifdef TRDB_ARCH64
  parameter int XLEN      = 64,
`else
  parameter int XLEN      = 32,
`endif
  parameter int CAUSE_LEN = 5,
  parameter int PRIV_LEN  = 2,
  parameter int INST_LEN  = 32,
  localparam int ELEN = 2*XLEN + INST_LEN + ITYPE_LEN + 4 + CAUSE_LEN + PRIV_LEN,
  localparam int CW   = $clog2(DEPTH) + 1
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      flush_i,
  input  logic [NRET-1:0]           valid_i,
  input  logic [NRET*XLEN-1:0]      pc_i,
  input  logic [NRET*INST_LEN-1:0]  inst_i,
  input  logic [NRET-1:0]           compressed_i,
  input  logic [NRET-1:0]           taken_i,
  input  logic [NRET-1:0]           exception_i,
  input  logic [NRET-1:0]           interrupt_i,
  input  logic [NRET*CAUSE_LEN-1:0] cause_i,
  input  logic [NRET*XLEN-1:0]      tval_i,
  input  logic [PRIV_LEN-1:0]       priv_i,
  output logic                      ready_o,
  output logic                      uop_valid_o,
  input  logic                      uop_ready_i,
  output logic [ELEN-1:0]           uop_o,
  output logic [CW-1:0]             count_o,
  output logic                      overflow_o
);

  localparam int PW = $clog2(DEPTH);

  localparam logic [3:0] IT_STD  = 4'd0;
  localparam logic [3:0] IT_EXC  = 4'd1;
  localparam logic [3:0] IT_INT  = 4'd2;
  localparam logic [3:0] IT_ERET = 4'd3;
  localparam logic [3:0] IT_NTB  = 4'd4;
  localparam logic [3:0] IT_TB   = 4'd5;
  localparam logic [3:0] IT_UIJ3 = 4'd6;
  localparam logic [3:0] IT_UC   = 4'd8;
  localparam logic [3:0] IT_IC   = 4'd9;
  localparam logic [3:0] IT_UIJ  = 4'd10;
  localparam logic [3:0] IT_IJ   = 4'd11;
  localparam logic [3:0] IT_CRS  = 4'd12;
  localparam logic [3:0] IT_RET  = 4'd13;

  logic [ELEN-1:0] mem [DEPTH];
  logic [ELEN-1:0] entry [NRET];
  logic [PW-1:0]   ofs [NRET];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count, n_push, acc;
  logic [CW:0]     space;
  logic [3:0]      cls;
  logic            overflow, push, pop;

  function automatic logic is_link(input logic [4:0] r);
    return (r == 5'd1) || (r == 5'd5);
  endfunction

  // Full itype decode for one lane; code is returned 4 bits wide and
  // truncated to ITYPE_LEN by the caller (base set never exceeds 6).
  function automatic logic [3:0] classify(input logic [31:0] w, input logic comp,
                                          input logic taken, input logic exc,
                                          input logic intr);
    logic [4:0] rd, rs1, crs1;
    logic is_eret, is_br, is_jalr, is_jal, is_cjr, is_cjalr, is_cj, is_cjal;
    rd   = w[11:7];
    rs1  = w[19:15];
    crs1 = w[11:7];
    is_eret  = !comp && (w == 32'h30200073 || w == 32'h10200073 || w == 32'h00200073);
    is_br    = (!comp && w[6:0] == 7'h63) ||
               (comp && (w[15:0] & 16'he003) == 16'hc001) ||
               (comp && (w[15:0] & 16'he003) == 16'he001);
    is_jalr  = !comp && (w & 32'h0000707f) == 32'h00000067;
    is_jal   = !comp && w[6:0] == 7'h6f;
    is_cjr   = comp && (w[15:0] & 16'hf07f) == 16'h8002 && crs1 != 5'd0;
    is_cjalr = comp && (w[15:0] & 16'hf07f) == 16'h9002 && crs1 != 5'd0;
    is_cj    = comp && (w[15:0] & 16'he003) == 16'ha001;
    is_cjal  = comp && (XLEN == 32) && (w[15:0] & 16'he003) == 16'h2001;
    if (intr)         return IT_INT;
    else if (exc)     return IT_EXC;
    else if (is_eret) return IT_ERET;
    else if (is_br)   return taken ? IT_TB : IT_NTB;
    else if (ITYPE_LEN == 3) begin
      if (is_jalr || is_cjr || is_cjalr) return IT_UIJ3;
      else return IT_STD;
    end else begin
      if (is_jalr) begin
        if (is_link(rd) && is_link(rs1) && rd != rs1) return IT_CRS;
        else if (is_link(rd))                         return IT_UC;
        else if (is_link(rs1))                        return IT_RET;
        else                                          return IT_UIJ;
      end
      else if (is_cjalr) return (crs1 == 5'd5) ? IT_CRS : IT_UC;
      else if (is_cjr)   return is_link(crs1) ? IT_RET : IT_UIJ;
      else if (is_jal)   return is_link(rd) ? IT_IC : IT_IJ;
      else if (is_cjal)  return IT_IC;
      else if (is_cj)    return IT_IJ;
      else               return IT_STD;
    end
  endfunction

  // Per-lane entry build and compaction offsets (valid lanes before this one).
  always_comb begin
    acc = '0;
    cls = '0;
    for (int l = 0; l < NRET; l++) begin
      ofs[l] = acc[PW-1:0];
      if (valid_i[l]) acc = acc + CW'(1);
      cls = classify(inst_i[l*INST_LEN +: 32], compressed_i[l], taken_i[l],
                     exception_i[l], interrupt_i[l]);
      entry[l] = {pc_i[l*XLEN +: XLEN], inst_i[l*INST_LEN +: INST_LEN],
                  cls[ITYPE_LEN-1:0], compressed_i[l], exception_i[l],
                  interrupt_i[l], (cls == IT_ERET), cause_i[l*CAUSE_LEN +: CAUSE_LEN],
                  tval_i[l*XLEN +: XLEN], priv_i};
    end
    n_push = acc;
  end

  assign space   = (CW+1)'(DEPTH) - (CW+1)'(count);
  assign ready_o = space >= (CW+1)'(NRET);
  assign push    = (|valid_i) && ready_o && !flush_i;
  assign pop     = (count != '0) && uop_ready_i && !flush_i;

  // Storage write: valid lanes land contiguously from the write pointer.
  always_ff @(posedge clk_i) begin
    if (push) begin
      for (int l = 0; l < NRET; l++) begin
        if (valid_i[l]) mem[wr_ptr + ofs[l]] <= entry[l];
      end
    end
  end

  // Pointers, occupancy and sticky overflow; flush outranks push and pop.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (flush_i) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + n_push[PW-1:0];
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + (push ? n_push : '0) - (pop ? CW'(1) : '0);
      if ((|valid_i) && !ready_o) overflow <= 1'b1;
    end
  end

  assign uop_o       = mem[rd_ptr];
  assign uop_valid_o = count != '0;
  assign count_o     = count;
  assign overflow_o  = overflow;

endmodule
